// File: rtl/switch_debounce_sync.sv
// Per-channel 2-flop synchroniser plus hold-counter debounce FSM for raw switches/buttons.
// Define DB_EDGE_PULSE_EN to generate rise_pulse/fall_pulse; otherwise both are tied to 0.
module switch_debounce_sync #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic [1:0] S_LO  = 2'd0;
  localparam logic [1:0] S_WHI = 2'd1;
  localparam logic [1:0] S_HI  = 2'd2;
  localparam logic [1:0] S_WLO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [1:0]       state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             db_reg, db_next;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        db_next    = db_reg;
        case (state_reg)
          S_LO: begin
            db_next = 1'b0;
            if (sync2_reg[gi]) begin
              state_next = S_WHI;
              cnt_next   = '0;
            end
          end
          S_WHI: begin
            // A return to 0 abandons the candidate level; the hold restarts from 0 later.
            if (!sync2_reg[gi]) begin
              state_next = S_LO;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = S_HI;
              db_next    = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          S_HI: begin
            db_next = 1'b1;
            if (!sync2_reg[gi]) begin
              state_next = S_WLO;
              cnt_next   = '0;
            end
          end
          S_WLO: begin
            if (sync2_reg[gi]) begin
              state_next = S_HI;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = S_LO;
              db_next    = 1'b0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = S_LO;
            db_next    = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= S_LO;
          cnt_reg   <= '0;
          db_reg    <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          db_reg    <= db_next;
        end
      end

      assign db_out[gi] = db_reg;

`ifdef DB_EDGE_PULSE_EN
      logic rise_reg, fall_reg;

      // Only an accepted hold moves WHI->HI or WLO->LO, so these transitions mark the edges.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= (state_reg == S_WHI) && (state_next == S_HI);
          fall_reg <= (state_reg == S_WLO) && (state_next == S_LO);
        end
      end

      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
`else
      assign rise_pulse[gi] = 1'b0;
      assign fall_pulse[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Scoreboard bench for switch_debounce_sync (WIDTH=2, CNT_MAX=4, CNT_W=3).
// Expected outputs come from a run-length model: a level is accepted after CNT_MAX+1 samples.
module tb_switch_debounce_sync;

  localparam int WIDTH   = 2;
  localparam int CNT_MAX = 4;
  localparam int CNT_W   = 3;

`ifdef DB_EDGE_PULSE_EN
  localparam int PULSE_EN = 1;
`else
  localparam int PULSE_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] raw_in = '0;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  switch_debounce_sync #(
    .WIDTH  (WIDTH),
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {db, rise, fall}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  logic [1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  int         m_run[2];

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    m_run[0] = 0; m_run[1] = 0;
  endfunction

  function automatic void model_edge();
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == CNT_MAX + 1) begin
          m_db[i]  = ~m_db[i];
          m_run[i] = 0;
          if (PULSE_EN != 0) begin
            if (m_db[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw_in;
  endfunction

  task automatic step(input logic [1:0] r);
    raw_in = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    exp_q.push_back({m_db, m_rise, m_fall});
    @(negedge clk);
    obs_q.push_back({db_out, rise_pulse, fall_pulse});
    $display("t=%0t rst_n=%b raw=%b db=%b rise=%b fall=%b", $time, rst_n, r, db_out, rise_pulse, fall_pulse);
  endtask

  task automatic do_reset(input logic [1:0] r);
    rst_n = 1'b0;
    model_reset();
    step(r);
    step(r);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    logic [5:0] e, o;
    int first;
    rst_n  = 1'b0;
    raw_in = 2'b11;
    model_reset();
    #1;
    checks++;
    if ({db_out, rise_pulse, fall_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: got %b required 000000", {db_out, rise_pulse, fall_pulse});
    end
    for (int s = 0; s < 3; s++) step(2'b11);
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) step(2'b11);
    first = -1;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_sb[%0d]: got %b required %b", j, o, e);
      end
      if (first < 0 && o[5:4] == 2'b11) first = j - 3;
    end
    checks++;
    if (first != CNT_MAX + 2) begin
      errors++;
      $display("FAIL reset_latency: got %0d required %0d", first, CNT_MAX + 2);
    end
  endtask

  task automatic test_rise();
    logic [5:0] e, o;
    int first, rises;
    do_reset(2'b00);
    for (int s = 0; s < 10; s++) step(2'b01);
    first = -1;
    rises = 0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rise_sb[%0d]: got %b required %b", j, o, e);
      end
      if (first < 0 && o[4]) first = j;
      if (o[2]) rises++;
    end
    checks++;
    if (first != CNT_MAX + 2) begin
      errors++;
      $display("FAIL rise_latency: got %0d required %0d", first, CNT_MAX + 2);
    end
    checks++;
    if (rises != PULSE_EN) begin
      errors++;
      $display("FAIL rise_pulse_count: got %0d required %0d", rises, PULSE_EN);
    end
  endtask

  task automatic test_glitch();
    logic [5:0] e, o;
    int highs, rises;
    do_reset(2'b00);
    for (int s = 0; s < 3; s++) step(2'b01);
    for (int s = 0; s < 8; s++) step(2'b00);
    highs = 0;
    rises = 0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL glitch_sb[%0d]: got %b required %b", j, o, e);
      end
      if (o[4]) highs++;
      if (o[2]) rises++;
    end
    checks++;
    if (highs != 0 || rises != 0) begin
      errors++;
      $display("FAIL glitch_reject: got db_high=%0d rises=%0d required 0 0", highs, rises);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] e, o;
    logic prev;
    int fall_at, falls;
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b00;
    do_reset(2'b00);
    for (int s = 0; s < 8; s++) step(2'b01);
    for (int s = 0; s < 4; s++) step(seq[s]);
    for (int s = 0; s < 8; s++) step(2'b00);
    prev = 1'b0;
    fall_at = -1;
    falls = 0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_sb[%0d]: got %b required %b", j, o, e);
      end
      if (prev && !o[4] && fall_at < 0) fall_at = j;
      prev = o[4];
      if (o[0]) falls++;
    end
    // Last raw 0 is first sampled at step 11 (8 setup + index 3 of the bounce).
    checks++;
    if (fall_at != 11 + CNT_MAX + 2) begin
      errors++;
      $display("FAIL bounce_latency: got %0d required %0d", fall_at, 11 + CNT_MAX + 2);
    end
    checks++;
    if (falls != PULSE_EN) begin
      errors++;
      $display("FAIL bounce_fall_count: got %0d required %0d", falls, PULSE_EN);
    end
  endtask

  task automatic test_both();
    logic [5:0] e, o;
    int first;
    logic [5:0] at_first;
    do_reset(2'b00);
    step(2'b00);
    for (int s = 0; s < 8; s++) step(2'b11);
    first = -1;
    at_first = '0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL both_sb[%0d]: got %b required %b", j, o, e);
      end
      if (first < 0 && o[5:4] != 2'b00) begin
        first = j;
        at_first = o;
      end
    end
    checks++;
    if (first != 1 + CNT_MAX + 2 || at_first[5:4] != 2'b11) begin
      errors++;
      $display("FAIL both_parallel: got step %0d db=%b required step %0d db=11", first, at_first[5:4], 1 + CNT_MAX + 2);
    end
    checks++;
    if (at_first[3:2] != (PULSE_EN != 0 ? 2'b11 : 2'b00)) begin
      errors++;
      $display("FAIL both_rise: got %b required %b", at_first[3:2], (PULSE_EN != 0 ? 2'b11 : 2'b00));
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({db_out, rise_pulse, fall_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL both_async_reset: got %b required 000000", {db_out, rise_pulse, fall_pulse});
    end
    step(2'b11);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [5:0] e, o;
    int first;
    do_reset(2'b00);
    for (int s = 0; s < 5; s++) step(2'b01);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_pre_sb: got %b required %b", o, e);
      end
    end
    do_reset(2'b01);
    for (int s = 0; s < 9; s++) step(2'b01);
    first = -1;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_sb[%0d]: got %b required %b", j, o, e);
      end
      if (first < 0 && o[4]) first = j;
    end
    checks++;
    if (first != CNT_MAX + 2) begin
      errors++;
      $display("FAIL mid_full_hold: got %0d required %0d", first, CNT_MAX + 2);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_both();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
